// File: rtl/plru_multiset.sv
// Multi-set tree pseudo-LRU replacement with per-way valid bits, single-way invalidation
// and a one-set-per-cycle full flush.
module plru_multiset #(
    parameter int unsigned WAYS_NUM = 4,
    parameter int unsigned SETS_NUM = 16,
    parameter int unsigned SET_W    = $clog2(SETS_NUM),
    parameter int unsigned WAY_W    = $clog2(WAYS_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic             req_hit,
    input  logic [WAY_W-1:0] req_hit_way,
    input  logic             inv_valid,
    input  logic [SET_W-1:0] inv_set,
    input  logic [WAY_W-1:0] inv_way,
    input  logic             flush_req,
    output logic             busy,
    output logic             rsp_valid,
    output logic [WAY_W-1:0] rsp_way,
    output logic             rsp_evict
);

    localparam int unsigned NodesNum = WAYS_NUM - 1;
    localparam logic [SET_W-1:0] LastSet = SET_W'(SETS_NUM - 1);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e state_q, state_d;
    logic [SET_W-1:0] cnt_q;

    logic [SETS_NUM-1:0][NodesNum-1:0] tree_q, tree_d;
    logic [SETS_NUM-1:0][WAYS_NUM-1:0] valid_q, valid_d;

    logic                rsp_valid_q, rsp_evict_q;
    logic [WAY_W-1:0]    rsp_way_q;
    logic                accept;
    logic [NodesNum-1:0] set_tree;
    logic [WAYS_NUM-1:0] set_valid;
    logic [WAY_W-1:0]    low_inv_way, way_d;
    logic                evict_d;

    // Node index never exceeds NodesNum-1, so WAY_W bits are enough; overflow on the
    // last level is harmless because that index is never used.
    function automatic logic [WAY_W-1:0] tree_victim(input logic [NodesNum-1:0] t);
        logic [WAY_W-1:0] n;
        logic [WAY_W-1:0] v;
        n = '0;
        v = '0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            v[l] = t[n];
            n    = (n << 1) + (t[n] ? WAY_W'(2) : WAY_W'(1));
        end
        return v;
    endfunction

    function automatic logic [NodesNum-1:0] tree_touch(input logic [NodesNum-1:0] t,
                                                       input logic [WAY_W-1:0]    w);
        logic [WAY_W-1:0]    n;
        logic [NodesNum-1:0] r;
        n = '0;
        r = t;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            r[n] = ~w[l];
            n    = (n << 1) + (w[l] ? WAY_W'(2) : WAY_W'(1));
        end
        return r;
    endfunction

    // Flush FSM: state register / next state / outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (flush_req) state_d = StFlush;
            StFlush: if (cnt_q == LastSet) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StFlush);
    end

    assign req_ready = ~busy & ~inv_valid;
    assign accept    = req_valid & req_ready;
    assign set_tree  = tree_q[req_set];
    assign set_valid = valid_q[req_set];

    always_comb begin
        low_inv_way = '0;
        for (int i = WAYS_NUM - 1; i >= 0; i--) begin
            if (!set_valid[i]) low_inv_way = WAY_W'(i);
        end
    end

    always_comb begin
        way_d   = '0;
        evict_d = 1'b0;
        if (req_hit) begin
            way_d = req_hit_way;
        end else if (!(&set_valid)) begin
            way_d = low_inv_way;
        end else begin
            way_d   = tree_victim(set_tree);
            evict_d = 1'b1;
        end
    end

    always_comb begin
        tree_d  = tree_q;
        valid_d = valid_q;
        if (busy) begin
            tree_d[cnt_q]  = '0;
            valid_d[cnt_q] = '0;
        end else if (inv_valid) begin
            valid_d[inv_set][inv_way] = 1'b0;
        end else if (req_valid) begin
            tree_d[req_set] = tree_touch(set_tree, way_d);
            if (!req_hit) valid_d[req_set][way_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tree_q  <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            tree_q  <= tree_d;
            valid_q <= valid_d;
            cnt_q   <= busy ? cnt_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_way_q   <= '0;
            rsp_evict_q <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_way_q   <= way_d;
                rsp_evict_q <= evict_d;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_way   = rsp_way_q;
    assign rsp_evict = rsp_evict_q;

endmodule

// File: tb/tb_plru_multiset.sv
// Directed bench for plru_multiset (4 ways, 16 sets): fill order, PLRU victim choice,
// invalidation, flush timing and asynchronous reset during a flush.
module tb_plru_multiset;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_set = '0;
    logic       req_hit = 1'b0;
    logic [1:0] req_hit_way = '0;
    logic       inv_valid = 1'b0;
    logic [3:0] inv_set = '0;
    logic [1:0] inv_way = '0;
    logic       flush_req = 1'b0;
    logic       busy;
    logic       rsp_valid;
    logic [1:0] rsp_way;
    logic       rsp_evict;

    int n_checks = 0;
    int n_fail   = 0;

    plru_multiset #(
        .WAYS_NUM(4),
        .SETS_NUM(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_set     (req_set),
        .req_hit     (req_hit),
        .req_hit_way (req_hit_way),
        .inv_valid   (inv_valid),
        .inv_set     (inv_set),
        .inv_way     (inv_way),
        .flush_req   (flush_req),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_way     (rsp_way),
        .rsp_evict   (rsp_evict)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1);
    end

    task automatic apply_reset();
        rst = 1'b0;
        req_valid = 1'b0;
        inv_valid = 1'b0;
        flush_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One accepted lookup; returns 1 ns after the edge, when the response is visible.
    task automatic access(input logic [3:0] s, input logic h, input logic [1:0] w);
        req_valid   = 1'b1;
        req_set     = s;
        req_hit     = h;
        req_hit_way = w;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_hit   = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({busy, rsp_valid, rsp_way, rsp_evict, req_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b vld=%b way=%0d ev=%b rdy=%b, expected 0 0 0 0 1",
                     busy, rsp_valid, rsp_way, rsp_evict, req_ready);
        end
    endtask

    task automatic test_fill_evict();
        logic [1:0] ew;
        logic       ee;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            access(4'd3, 1'b0, 2'd0);
            ew = (i == 4) ? 2'd0 : 2'(i);
            ee = (i == 4);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_way !== ew || rsp_evict !== ee) begin
                n_fail++;
                $display("FAIL fill_miss%0d: got vld=%b way=%0d ev=%b, expected 1 %0d %b",
                         i, rsp_valid, rsp_way, rsp_evict, ew, ee);
            end
        end
    endtask

    task automatic test_hit_plru();
        apply_reset();
        for (int i = 0; i < 4; i++) access(4'd3, 1'b0, 2'd0);
        access(4'd3, 1'b1, 2'd0);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_way !== 2'd0 || rsp_evict !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_way0: got vld=%b way=%0d ev=%b, expected 1 0 0",
                     rsp_valid, rsp_way, rsp_evict);
        end
        access(4'd3, 1'b0, 2'd0);
        n_checks++;
        if (rsp_way !== 2'd2 || rsp_evict !== 1'b1) begin
            n_fail++;
            $display("FAIL plru_victim: got way=%0d ev=%b, expected 2 1", rsp_way, rsp_evict);
        end
        access(4'd4, 1'b0, 2'd0);
        n_checks++;
        if (rsp_way !== 2'd0 || rsp_evict !== 1'b0) begin
            n_fail++;
            $display("FAIL set4_untouched: got way=%0d ev=%b, expected 0 0", rsp_way, rsp_evict);
        end
    endtask

    task automatic test_invalidate();
        apply_reset();
        for (int i = 0; i < 4; i++) access(4'd5, 1'b0, 2'd0);
        inv_valid = 1'b1;
        inv_set   = 4'd5;
        inv_way   = 2'd2;
        req_valid = 1'b1;
        req_set   = 4'd5;
        req_hit   = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_blocks_ready: got %b, expected 0", req_ready);
        end
        @(posedge clk);
        #1;
        inv_valid = 1'b0;
        req_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_no_rsp: got rsp_valid=%b, expected 0", rsp_valid);
        end
        access(4'd5, 1'b0, 2'd0);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_way !== 2'd2 || rsp_evict !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_after_inv: got vld=%b way=%0d ev=%b, expected 1 2 0",
                     rsp_valid, rsp_way, rsp_evict);
        end
    endtask

    task automatic test_flush();
        int busy_cycles;
        int ready_bad;
        apply_reset();
        for (int i = 0; i < 4; i++) access(4'd0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) access(4'd15, 1'b0, 2'd0);
        // Lookup and flush request in the same idle cycle.
        req_valid = 1'b1;
        req_set   = 4'd0;
        req_hit   = 1'b0;
        flush_req = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_with_flush: got %b, expected 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush_req = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_way, rsp_evict, busy} !== 5'b1_00_1_1) begin
            n_fail++;
            $display("FAIL req_then_flush: got vld=%b way=%0d ev=%b busy=%b, expected 1 0 1 1",
                     rsp_valid, rsp_way, rsp_evict, busy);
        end
        busy_cycles = 0;
        ready_bad   = 0;
        while (busy === 1'b1 && busy_cycles < 64) begin
            if (req_ready !== 1'b0) ready_bad++;
            flush_req = (busy_cycles == 8);
            busy_cycles++;
            @(posedge clk);
            #1;
        end
        flush_req = 1'b0;
        n_checks++;
        if (busy_cycles != 16) begin
            n_fail++;
            $display("FAIL flush_duration: got %0d busy cycles, expected 16", busy_cycles);
        end
        n_checks++;
        if (ready_bad != 0) begin
            n_fail++;
            $display("FAIL flush_ready_low: got %0d cycles ready=1, expected 0", ready_bad);
        end
        access(4'd0, 1'b0, 2'd0);
        n_checks++;
        if (rsp_way !== 2'd0 || rsp_evict !== 1'b0) begin
            n_fail++;
            $display("FAIL post_flush_set0: got way=%0d ev=%b, expected 0 0", rsp_way, rsp_evict);
        end
        access(4'd15, 1'b0, 2'd0);
        n_checks++;
        if (rsp_way !== 2'd0 || rsp_evict !== 1'b0) begin
            n_fail++;
            $display("FAIL post_flush_set15: got way=%0d ev=%b, expected 0 0", rsp_way, rsp_evict);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req_valid = 1'b1;
        req_set   = 4'd7;
        req_hit   = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_way !== 2'd0 || rsp_evict !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got vld=%b way=%0d ev=%b, expected 1 0 0",
                     rsp_valid, rsp_way, rsp_evict);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_way !== 2'd1 || rsp_evict !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got vld=%b way=%0d ev=%b, expected 1 1 0",
                     rsp_valid, rsp_way, rsp_evict);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_single_cycle: got rsp_valid=%b, expected 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        for (int i = 0; i < 4; i++) access(4'd10, 1'b0, 2'd0);
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_at_cycle6: got %b, expected 1", busy);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_abort: got busy=%b vld=%b, expected 0 0", busy, rsp_valid);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        access(4'd10, 1'b0, 2'd0);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_way !== 2'd0 || rsp_evict !== 1'b0) begin
            n_fail++;
            $display("FAIL set10_after_reset: got vld=%b way=%0d ev=%b, expected 1 0 0",
                     rsp_valid, rsp_way, rsp_evict);
        end
    endtask

    initial begin
        test_reset();
        test_fill_evict();
        test_hit_plru();
        test_invalidate();
        test_flush();
        test_back_to_back();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
